// File: rtl/tile_flusher.sv
// tile_flusher: drains one 8x8 RGB565 nanoTile into the framebuffer over a req/ack
// write port. Pixels are visited row-major. Off-screen and key-coloured pixels are
// skipped at one cycle each, so a partially covered tile leaves the rest of the
// framebuffer untouched.
module tile_flusher #(
  parameter int unsigned nanoTileDim = 8,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              BOARD_CLK,
  input  logic              RESET_N,
  input  logic [15:0]       nanoTile0 [nanoTileDim][nanoTileDim],
  input  logic [15:0]       nanoTile1 [nanoTileDim][nanoTileDim],
  input  logic              flushStart,
  input  logic              flushTileID,
  input  logic [9:0]        flushOffsetX,
  input  logic [9:0]        flushOffsetY,
  input  logic              keyEnable,
  input  logic [15:0]       keyColor,
  output logic              wrReq,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [15:0]       wrData,
  input  logic              wrAck,
  output logic              flushBusy,
  output logic              flushDone
);

  localparam int unsigned PW = $clog2(nanoTileDim);
  localparam logic [PW-1:0] PMax = PW'(nanoTileDim - 1);
  localparam logic [10:0] ScreenW11 = 11'(SCREEN_W);
  localparam logic [10:0] ScreenH11 = 11'(SCREEN_H);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     px_q, px_d, py_q, py_d;
  logic              tile_id_q, tile_id_d;
  logic [9:0]        off_x_q, off_x_d, off_y_q, off_y_d;
  logic              key_en_q, key_en_d;
  logic [15:0]       key_col_q, key_col_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Pixel evaluation inputs: live ports when accepting, latched command otherwise.
  logic          ev_tile, ev_key_en;
  logic [9:0]    ev_off_x, ev_off_y;
  logic [15:0]   ev_key_col, ev_pix;
  logic [PW-1:0] ev_px, ev_py, px_nxt, py_nxt;
  logic [10:0]   ev_sx, ev_sy;
  logic          ev_skip, last_pix;
  logic [ADDR_W-1:0] ev_addr;

  // Row-major successor of the current pixel and the tail detection.
  always_comb begin
    px_nxt   = (px_q == PMax) ? '0 : px_q + 1'b1;
    py_nxt   = (px_q == PMax) ? py_q + 1'b1 : py_q;
    last_pix = (px_q == PMax) && (py_q == PMax);
  end

  // Evaluate the pixel whose request will be registered at the next edge.
  always_comb begin
    if (state_q == StIdle) begin
      ev_tile    = flushTileID;
      ev_off_x   = flushOffsetX;
      ev_off_y   = flushOffsetY;
      ev_key_en  = keyEnable;
      ev_key_col = keyColor;
      ev_px      = '0;
      ev_py      = '0;
    end else begin
      ev_tile    = tile_id_q;
      ev_off_x   = off_x_q;
      ev_off_y   = off_y_q;
      ev_key_en  = key_en_q;
      ev_key_col = key_col_q;
      ev_px      = px_nxt;
      ev_py      = py_nxt;
    end
    ev_sx   = {1'b0, ev_off_x} + 11'(ev_px);
    ev_sy   = {1'b0, ev_off_y} + 11'(ev_py);
    ev_pix  = ev_tile ? nanoTile1[ev_px][ev_py] : nanoTile0[ev_px][ev_py];
    ev_skip = (ev_sx >= ScreenW11) || (ev_sy >= ScreenH11) ||
              (ev_key_en && (ev_pix == ev_key_col));
    ev_addr = ADDR_W'(32'(ev_sy) * SCREEN_W + 32'(ev_sx));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    py_d      = py_q;
    tile_id_d = tile_id_q;
    off_x_d   = off_x_q;
    off_y_d   = off_y_q;
    key_en_d  = key_en_q;
    key_col_d = key_col_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d   = 1'b0;
        wr_req_d = 1'b0;
        if (flushStart) begin
          tile_id_d = flushTileID;
          off_x_d   = flushOffsetX;
          off_y_d   = flushOffsetY;
          key_en_d  = keyEnable;
          key_col_d = keyColor;
          px_d      = '0;
          py_d      = '0;
          busy_d    = 1'b1;
          state_d   = StWrite;
          wr_req_d  = !ev_skip;
          if (!ev_skip) begin
            wr_addr_d = ev_addr;
            wr_data_d = ev_pix;
          end
        end
      end
      StWrite: begin
        // A registered wrReq=0 in this state marks a skip cycle.
        if (!wr_req_q || wrAck) begin
          if (last_pix) begin
            state_d  = StDone;
            wr_req_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            px_d     = px_nxt;
            py_d     = py_nxt;
            wr_req_d = !ev_skip;
            if (!ev_skip) begin
              wr_addr_d = ev_addr;
              wr_data_d = ev_pix;
            end
          end
        end
      end
      StDone: begin
        state_d  = StIdle;
        busy_d   = 1'b0;
        wr_req_d = 1'b0;
      end
      default: begin
        state_d  = StIdle;
        busy_d   = 1'b0;
        wr_req_d = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any flush without a done pulse.
  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      px_q      <= '0;
      py_q      <= '0;
      tile_id_q <= 1'b0;
      off_x_q   <= '0;
      off_y_q   <= '0;
      key_en_q  <= 1'b0;
      key_col_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      py_q      <= py_d;
      tile_id_q <= tile_id_d;
      off_x_q   <= off_x_d;
      off_y_q   <= off_y_d;
      key_en_q  <= key_en_d;
      key_col_q <= key_col_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wrReq     = wr_req_q;
  assign wrAddr    = wr_addr_q;
  assign wrData    = wr_data_q;
  assign flushBusy = busy_q;
  assign flushDone = done_q;

endmodule

// File: tb/tb_tile_flusher.sv
// Directed bench for tile_flusher: full tiles, ack wait states, screen clipping,
// key-colour skipping, ignored re-start and mid-flush reset.
module tb_tile_flusher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tile0 [8][8];
  logic [15:0] tile1 [8][8];
  logic        flush_start, tile_id, key_en, wr_ack;
  logic [9:0]  off_x, off_y;
  logic [15:0] key_col;
  logic        wr_req, busy, done;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [19:0] wa_q[$];
  logic [15:0] wd_q[$];
  int done_cyc, first_req_cyc, skip_cnt, busy_gap, last_ack, extra;

  tile_flusher dut (
    .BOARD_CLK   (clk),
    .RESET_N     (rst_n),
    .nanoTile0   (tile0),
    .nanoTile1   (tile1),
    .flushStart  (flush_start),
    .flushTileID (tile_id),
    .flushOffsetX(off_x),
    .flushOffsetY(off_y),
    .keyEnable   (key_en),
    .keyColor    (key_col),
    .wrReq       (wr_req),
    .wrAddr      (wr_addr),
    .wrData      (wr_data),
    .wrAck       (wr_ack),
    .flushBusy   (busy),
    .flushDone   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Issue a start, then service the port until flushDone, logging accepted writes.
  task automatic run_flush(input logic tid, input logic [9:0] ox, input logic [9:0] oy,
                           input logic ke, input logic [15:0] kc, input int period,
                           input int pulse_cyc, input string tag);
    logic        waiting;
    logic [19:0] wa;
    logic [15:0] wd;
    wa_q.delete();
    wd_q.delete();
    done_cyc = 0; first_req_cyc = 0; skip_cnt = 0; busy_gap = 0; last_ack = 0;
    waiting = 1'b0; wa = '0; wd = '0;
    tile_id = tid; off_x = ox; off_y = oy; key_en = ke; key_col = kc;
    wr_ack = 1'b0;
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (waiting) begin
        check({tag, " hold req"}, 32'(wr_req), 32'd1);
        check({tag, " hold addr"}, 32'(wr_addr), 32'(wa));
        check({tag, " hold data"}, 32'(wr_data), 32'(wd));
        waiting = 1'b0;
      end
      if (!busy) busy_gap++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      flush_start = (cyc == pulse_cyc);
      tile_id     = (cyc == pulse_cyc) ? 1'b1 : tid;
      wr_ack      = ((cyc % period) == 0);
      if (wr_req) begin
        if (first_req_cyc == 0) first_req_cyc = cyc;
        if (wr_ack) begin
          wa_q.push_back(wr_addr);
          wd_q.push_back(wr_data);
          last_ack = cyc;
        end else begin
          waiting = 1'b1;
          wa = wr_addr;
          wd = wr_data;
        end
      end else begin
        skip_cnt++;
      end
      tick();
    end
    flush_start = 1'b0;
    wr_ack = 1'b0;
    check({tag, " done seen"}, 32'(done_cyc != 0), 32'd1);
    check({tag, " busy gaps"}, 32'(busy_gap), 32'd0);
  endtask

  // Compare the logged writes against a full unclipped tile of value py*8+px.
  task automatic check_full_tile(input string tag, input int ox, input int oy);
    check({tag, " write count"}, 32'(wa_q.size()), 32'd64);
    for (int i = 0; i < 64; i++) begin
      check({tag, " addr"}, 32'(wa_q[i]), 32'((oy + i / 8) * 640 + ox + i % 8));
      check({tag, " data"}, 32'(wd_q[i]), 32'(i));
    end
  endtask

  task automatic fill_tiles();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        tile0[x][y] = 16'(y * 8 + x);
        tile1[x][y] = 16'(16'h1000 + y * 8 + x);
      end
  endtask

  initial begin
    rst_n = 1'b0;
    flush_start = 1'b0; tile_id = 1'b0; off_x = '0; off_y = '0;
    key_en = 1'b0; key_col = 16'hF81F; wr_ack = 1'b0;
    fill_tiles();
    repeat (3) tick();
    check("reset wrReq", 32'(wr_req), 32'd0);
    check("reset wrAddr", 32'(wr_addr), 32'd0);
    check("reset wrData", 32'(wr_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle busy", 32'(busy), 32'd0);

    // Full tile at origin, ack tied high.
    run_flush(1'b0, 10'd0, 10'd0, 1'b0, 16'hF81F, 1, 0, "t1");
    check("t1 first req cycle", 32'(first_req_cyc), 32'd1);
    check("t1 done cycle", 32'(done_cyc), 32'd65);
    check("t1 skips", 32'(skip_cnt), 32'd0);
    check_full_tile("t1", 0, 0);
    tick();
    check("t1 busy after done", 32'(busy), 32'd0);
    check("t1 done pulse width", 32'(done), 32'd0);

    // Offset tile with an ack only every third cycle.
    run_flush(1'b0, 10'd16, 10'd2, 1'b0, 16'hF81F, 3, 0, "t2");
    check("t2 first addr", 32'(wa_q[0]), 32'd1296);
    check("t2 done cycle", 32'(done_cyc), 32'd193);
    check("t2 done after last ack", 32'(done_cyc), 32'(last_ack + 1));
    check_full_tile("t2", 16, 2);
    tick();

    // Bottom-right corner: only the on-screen 4x4 quadrant of tile1 is written.
    run_flush(1'b1, 10'd636, 10'd476, 1'b0, 16'hF81F, 1, 0, "t3");
    check("t3 write count", 32'(wa_q.size()), 32'd16);
    check("t3 first addr", 32'(wa_q[0]), 32'd305276);
    check("t3 skips", 32'(skip_cnt), 32'd48);
    check("t3 done cycle", 32'(done_cyc), 32'd65);
    for (int i = 0; i < 16; i++) begin
      check("t3 addr", 32'(wa_q[i]), 32'((476 + i / 4) * 640 + 636 + i % 4));
      check("t3 data", 32'(wd_q[i]), 32'(16'h1000 + (i / 4) * 8 + i % 4));
    end
    tick();

    // Key colour everywhere except one pixel.
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) tile0[x][y] = 16'hF81F;
    tile0[3][5] = 16'h07E0;
    run_flush(1'b0, 10'd0, 10'd0, 1'b1, 16'hF81F, 1, 0, "t4");
    check("t4 write count", 32'(wa_q.size()), 32'd1);
    check("t4 addr", 32'(wa_q[0]), 32'd3203);
    check("t4 data", 32'(wd_q[0]), 32'h07E0);
    check("t4 skips", 32'(skip_cnt), 32'd63);
    check("t4 done cycle", 32'(done_cyc), 32'd65);
    fill_tiles();
    tick();

    // Re-start pulsed mid-flush must be ignored and not queued.
    run_flush(1'b0, 10'd0, 10'd0, 1'b0, 16'hF81F, 1, 10, "t5");
    check("t5 done cycle", 32'(done_cyc), 32'd65);
    check_full_tile("t5", 0, 0);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy || done || wr_req) extra++;
    end
    check("t5 no queued flush", 32'(extra), 32'd0);

    // Reset while pixel 20 is being requested.
    tile_id = 1'b0; off_x = '0; off_y = '0; key_en = 1'b0; wr_ack = 1'b1;
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    repeat (20) tick();
    check("t6 pixel20 req", 32'(wr_req), 32'd1);
    check("t6 pixel20 addr", 32'(wr_addr), 32'd1284);
    check("t6 pixel20 data", 32'(wr_data), 32'd20);
    rst_n = 1'b0;
    #1;
    check("t6 async wrReq drop", 32'(wr_req), 32'd0);
    check("t6 async busy drop", 32'(busy), 32'd0);
    extra = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (done || busy || wr_req) extra++;
    end
    check("t6 quiet in reset", 32'(extra), 32'd0);
    rst_n = 1'b1;
    wr_ack = 1'b0;
    tick();
    check("t6 no done after reset", 32'(done), 32'd0);
    check("t6 idle after reset", 32'(busy), 32'd0);
    run_flush(1'b0, 10'd0, 10'd0, 1'b0, 16'hF81F, 1, 0, "t6r");
    check("t6r first req cycle", 32'(first_req_cyc), 32'd1);
    check("t6r done cycle", 32'(done_cyc), 32'd65);
    check_full_tile("t6r", 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
